transpose_load_ctrl: RTL
========================

Name: transpose_load_ctrl

Overview:
- Sequences a bank of DIM parallel-load/shift transpose FIFOs (one per systolic-array row) in the matrix-multiply datapath.
- On start, fetches DIM rows of a DIM x DIM tile from a memory read port and parallel-loads row r into FIFO r.
- Then drives a common shift enable for exactly 3*DIM-2 cycles, with a zero shift-in value, so the full tile drains through the array.
- Signals done when the drain is complete.

Parameters:
- DIM, 8, number of FIFOs, FIFO depth, and tile rows/cols.
- BITS, 64, element width in bits (signed).
- ADDR_W, 32, memory byte-address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to begin a tile; sampled only in IDLE.
- base_addr  in  ADDR_W  byte address of tile row 0; captured on accepted start.
- stall  in  1  freezes the SHIFT phase while high.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on the SHIFT to IDLE transition.
- rd_req  out  1  memory read request; held until rd_valid.
- rd_addr  out  ADDR_W  row address = base + r*(DIM*BITS/8).
- rd_valid  in  1  read data valid; ignored when rd_req is low.
- rd_data  in  DIM x BITS signed  one tile row.
- fifo_wr_en  out  DIM  one-hot parallel-load strobe; bit r loads FIFO r.
- fifo_row  out  DIM x BITS signed  row data to all FIFO rowIn ports.
- fifo_en  out  1  shift enable to all FIFOs.
- fifo_d  out  BITS signed  shift-in value; constant 0.

Behaviour:
- Output drive: all outputs come from registers or a decode of registered state only (Moore); no combinational path from any input to any output.
- Reset values: state=IDLE, row counter r=0, shift counter=0, busy=0, done=0, rd_req=0, rd_addr=0, fifo_wr_en=0, fifo_row=0, fifo_en=0.
- IDLE:
  - On start=1, capture base_addr, clear r, go to REQ.
  - start while busy is ignored; no queueing.
- REQ:
  - Assert rd_req with rd_addr = base + r*ROW_BYTES; address is modulo 2^ADDR_W and wraps silently.
  - Stay in REQ until rd_valid=1 is sampled.
  - On that edge, register rd_data into fifo_row and go to LOAD.
- LOAD (exactly 1 cycle):
  - fifo_wr_en = (1<<r), rd_req=0.
  - If r==DIM-1, clear the shift counter and go to SHIFT; else r<=r+1 and go to REQ.
- Per-row cost:
  - 2 cycles when rd_valid arrives in the first REQ cycle.
  - Add 1 cycle per wait cycle.
- SHIFT:
  - fifo_en = ~stall; counter increments only when stall=0.
  - When the count reaches 3*DIM-2 non-stalled cycles, go to IDLE and pulse done in that transition cycle.
  - fifo_wr_en is never asserted in SHIFT, so parallel load and shift never coincide.
- Exclusivity:
  - fifo_wr_en and fifo_en are never high in the same cycle.
  - fifo_wr_en has at most one bit set.
- stall outside SHIFT has no effect.
- Reset mid-operation: all state returns to reset values immediately; any outstanding read is abandoned, and a late rd_valid is ignored (rd_req=0).
- Widths:
  - r is clog2(DIM) bits.
  - The shift counter is clog2(3*DIM-1) bits.
  - The address multiply is constant-shift/add, truncated to ADDR_W.

Decomposition:
- Package transpose_pkg holds:
  - state enum (IDLE, REQ, LOAD, SHIFT);
  - localparam ROW_BYTES = DIM*BITS/8;
  - localparam SHIFT_CYCLES = 3*DIM-2;
  - typedef row_t = logic signed [BITS-1:0] [DIM].
- One sub-module, tile_addr_gen: holds base, r, and the rd_addr computation with increment/clear controls.
- The FSM and shift counter live in the top block.

Test Plan (DIM=8, BITS=64):
- Basic tile: base_addr=0x1000, memory returns rd_valid 1 cycle after each req.
  - rd_addr sequence 0x1000, 0x1040, ..., 0x11C0.
  - fifo_wr_en 0x01..0x80 one-hot, with the matching rows.
  - Then fifo_en high for 22 cycles, then done for 1 cycle; total 24+22 cycles from start.
- Zero-latency memory (rd_valid in the same cycle as req): 2 cycles/row; done 16+22 cycles after the start-accept edge.
- Stall: assert stall for 5 cycles mid-SHIFT.
  - fifo_en=0 during those cycles.
  - SHIFT lasts 27 cycles; still exactly 22 fifo_en cycles.
- Back-pressure and spurious valid:
  - rd_valid delayed 4 cycles on row 3: rd_req and rd_addr=base+0xC0 held stable.
  - start pulses while busy: no effect.
  - rd_valid pulses in IDLE: no effect.
- Async reset mid-LOAD at row 5: all outputs 0 at once.
  - Late rd_valid ignored.
  - A new start restarts at row 0 with the new base.
- Address wrap: base_addr=0xFFFFFFC0 gives rd_addr 0xFFFFFFC0, 0x00000000, 0x00000040, ...; each row is still loaded into the correct FIFO.

Source files
------------

// File: rtl/transpose_pkg.sv
// rtl/transpose_pkg.sv - shared state encoding, tile constants and types for the transpose load sequencer
package transpose_pkg;

    localparam int DIM_DEF      = 8;
    localparam int BITS_DEF     = 64;
    localparam int ADDR_W_DEF   = 32;
    localparam int ROW_BYTES    = DIM_DEF * BITS_DEF / 8;
    localparam int SHIFT_CYCLES = 3 * DIM_DEF - 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        LOAD  = 2'd2,
        SHIFT = 2'd3
    } state_e;

    typedef logic signed [DIM_DEF-1:0][BITS_DEF-1:0] row_t;

    function automatic int row_bytes(input int dim, input int bits);
        return dim * bits / 8;
    endfunction

    // A full tile needs 3*DIM-2 shifts to drain through the systolic array.
    function automatic int shift_cycles(input int dim);
        return 3 * dim - 2;
    endfunction

endpackage

// File: rtl/tile_addr_gen.sv
// rtl/tile_addr_gen.sv - tile base/row registers and the row read address
module tile_addr_gen
    import transpose_pkg::*;
#(
    parameter int DIM    = DIM_DEF,
    parameter int BITS   = BITS_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int RW     = (DIM > 1) ? $clog2(DIM) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              inc_i,
    input  logic [ADDR_W-1:0] base_i,
    output logic [RW-1:0]     row_o,
    output logic [ADDR_W-1:0] addr_o
);

    localparam int ROW_B = row_bytes(DIM, BITS);
    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(ROW_B);

    logic [ADDR_W-1:0] base_q, base_d;
    logic [RW-1:0]     row_q, row_d;

    always_comb begin
        base_d = base_q;
        row_d  = row_q;
        if (load_i) begin
            base_d = base_i;
            row_d  = '0;
        end else if (inc_i) begin
            row_d = row_q + RW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
            row_q  <= '0;
        end else begin
            base_q <= base_d;
            row_q  <= row_d;
        end
    end

    // Constant stride multiply; the sum wraps modulo 2^ADDR_W by truncation.
    assign addr_o = base_q + ADDR_W'(row_q) * ROW_STRIDE;
    assign row_o  = row_q;

endmodule

// File: rtl/transpose_load_ctrl.sv
// rtl/transpose_load_ctrl.sv - loads a DIM x DIM tile row-by-row into the transpose FIFOs, then drains it
module transpose_load_ctrl
    import transpose_pkg::*;
#(
    parameter int DIM    = DIM_DEF,
    parameter int BITS   = BITS_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [ADDR_W-1:0]                 base_addr,
    input  logic                              stall,
    output logic                              busy,
    output logic                              done,
    output logic                              rd_req,
    output logic [ADDR_W-1:0]                 rd_addr,
    input  logic                              rd_valid,
    input  logic signed [DIM-1:0][BITS-1:0]   rd_data,
    output logic [DIM-1:0]                    fifo_wr_en,
    output logic signed [DIM-1:0][BITS-1:0]   fifo_row,
    output logic                              fifo_en,
    output logic signed [BITS-1:0]            fifo_d
);

    localparam int RW      = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int CW      = $clog2(3 * DIM - 1);
    localparam int SHIFT_N = shift_cycles(DIM);

    localparam logic [RW-1:0]  LAST_ROW   = RW'(DIM - 1);
    localparam logic [CW-1:0]  SHIFT_LAST = CW'(SHIFT_N - 1);
    localparam logic [DIM-1:0] ONE_HOT0   = DIM'(1);

    state_e                            state_q;
    logic [CW-1:0]                     shift_cnt_q;
    logic                              done_q;
    logic                              rd_req_q;
    logic                              fifo_en_q;
    logic [DIM-1:0]                    wr_en_q;
    logic signed [DIM-1:0][BITS-1:0]   row_data_q;

    logic [RW-1:0] row;
    logic          addr_load;
    logic          addr_inc;

    assign addr_load = (state_q == IDLE) && start;
    assign addr_inc  = (state_q == LOAD) && (row != LAST_ROW);

    tile_addr_gen #(
        .DIM    (DIM),
        .BITS   (BITS),
        .ADDR_W (ADDR_W),
        .RW     (RW)
    ) u_addr (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (addr_load),
        .inc_i  (addr_inc),
        .base_i (base_addr),
        .row_o  (row),
        .addr_o (rd_addr)
    );

    // fifo_en_q marks the current cycle as a shift; shift_cnt_q counts shifts already completed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shift_cnt_q <= '0;
            done_q      <= 1'b0;
            rd_req_q    <= 1'b0;
            fifo_en_q   <= 1'b0;
            wr_en_q     <= '0;
            row_data_q  <= '0;
        end else begin
            done_q  <= 1'b0;
            wr_en_q <= '0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        rd_req_q <= 1'b1;
                        state_q  <= REQ;
                    end
                end
                REQ: begin
                    if (rd_valid) begin
                        row_data_q <= rd_data;
                        wr_en_q    <= ONE_HOT0 << row;
                        rd_req_q   <= 1'b0;
                        state_q    <= LOAD;
                    end
                end
                LOAD: begin
                    if (row == LAST_ROW) begin
                        shift_cnt_q <= '0;
                        fifo_en_q   <= 1'b1;
                        state_q     <= SHIFT;
                    end else begin
                        rd_req_q <= 1'b1;
                        state_q  <= REQ;
                    end
                end
                SHIFT: begin
                    if (fifo_en_q && (shift_cnt_q == SHIFT_LAST)) begin
                        fifo_en_q <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        if (fifo_en_q) begin
                            shift_cnt_q <= shift_cnt_q + CW'(1);
                        end
                        fifo_en_q <= ~stall;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign rd_req     = rd_req_q;
    assign fifo_wr_en = wr_en_q;
    assign fifo_row   = row_data_q;
    assign fifo_en    = fifo_en_q;
    assign fifo_d     = '0;

    // Parallel load and shift must never overlap in the FIFO bank.
    assert property (@(posedge clk) disable iff (!rst_n) !((|wr_en_q) && fifo_en_q));
    assert property (@(posedge clk) disable iff (!rst_n) $onehot0(wr_en_q));

endmodule
